// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared FSM encoding, opcodes and counter sizing for serial_addsub
package serial_addsub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_addsub_fa_cell.sv
// fa_cell: combinational 1-bit full adder
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_cin;
  assign o_co = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/subtract, LSB-first through one full-adder cell
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = cnt_w(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_opa, r_opb, r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_busy, r_done, r_cout, r_ovf;
  logic [WIDTH-1:0] r_sum;
  logic             w_s, w_co;
  logic [WIDTH-1:0] w_res_nx;
  fa_cell u_fa (
    .i_a  (r_opa[0]),
    .i_b  (r_opb[0]),
    .i_cin(r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );
  // new sum bit enters at the MSB so the LSB-first stream lands in place
  assign w_res_nx = (r_res >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_opa   <= a;
          r_opb   <= (sub == OP_SUB) ? ~b : b;
          r_carry <= sub;
          r_cnt   <= '0;
          r_res   <= '0;
          r_busy  <= 1'b1;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_res   <= w_res_nx;
          r_opa   <= r_opa >> 1;
          r_opb   <= r_opb >> 1;
          r_carry <= w_co;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_sum   <= w_res_nx;
            r_cout  <= w_co;
            r_ovf   <= r_carry ^ w_co;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: randomized and directed checks of serial_addsub at WIDTH 8, 4 and 1
module tb_serial_addsub;
  logic       clk = 1'b0, rst_n = 1'b0, sub_in = 1'b0;
  logic [2:0] st = '0;
  logic [7:0] a_in = '0, b_in = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sub_in),
    .a(a_in), .b(b_in), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8));
  serial_addsub #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sub_in),
    .a(a_in[3:0]), .b(b_in[3:0]), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4));
  serial_addsub #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sub_in),
    .a(a_in[0:0]), .b(b_in[0:0]), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1));

  // reference: {overflow, cout, sum} from plain modular/signed arithmetic
  function automatic logic [9:0] ref_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic s);
    longint m, aa, bv, t, r, sa, sb, sr;
    logic c, o;
    m  = (64'd1 << w) - 1;
    aa = longint'(a) & m;
    bv = longint'(b) & m;
    t  = s ? aa + ((~bv) & m) + 1 : aa + bv;
    r  = t & m;
    c  = t[w];
    sa = (aa >> (w - 1)) & 1;
    sb = (bv >> (w - 1)) & 1;
    sr = (r >> (w - 1)) & 1;
    o  = s ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
    return {o, c, r[7:0]};
  endfunction

  function automatic logic dn_of(input int w);
    return (w == 8) ? done8 : (w == 4) ? done4 : done1;
  endfunction
  function automatic logic bs_of(input int w);
    return (w == 8) ? busy8 : (w == 4) ? busy4 : busy1;
  endfunction
  function automatic logic [9:0] res_of(input int w);
    return (w == 8) ? {ovf8, cout8, sum8} : (w == 4) ? {ovf4, cout4, 4'b0, sum4} : {ovf1, cout1, 7'b0, sum1};
  endfunction

  // starts one op from IDLE (#1 after an edge) and returns results, latency and busy-cycle count
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [9:0] res, output int cyc, output int nb);
    a_in = a; b_in = b; sub_in = s;
    st = (w == 8) ? 3'b001 : (w == 4) ? 3'b010 : 3'b100;
    @(posedge clk); #1;
    st = '0; a_in = 8'($urandom); b_in = 8'($urandom); sub_in = 1'($urandom);
    cyc = 0; nb = 0;
    while (!dn_of(w) && cyc < 100) begin
      nb += int'(bs_of(w));
      @(posedge clk); #1;
      cyc++;
    end
    nb += int'(bs_of(w));
    res = res_of(w);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h0) begin
      bad++; $display("FAIL reset got=%h exp=0", {busy8, done8, sum8, cout8, ovf8});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [7:0] ta [5] = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h80};
    logic [7:0] tb [5] = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h01};
    logic       ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0] te [5] = '{{2'b00, 8'h10}, {2'b01, 8'h00}, {2'b10, 8'h80}, {2'b00, 8'hFE}, {2'b11, 8'h7F}};
    logic [9:0] r;
    int cyc, nb;
    for (int i = 0; i < 5; i++) begin
      run_op(8, ta[i], tb[i], ts[i], r, cyc, nb);
      total++;
      if (r !== te[i]) begin
        bad++; $display("FAIL directed%0d result got=%h exp=%h", i, r, te[i]);
      end
      total++;
      if (cyc !== 8 || nb !== 8) begin
        bad++; $display("FAIL directed%0d latency/busy got=%0d/%0d exp=8/8", i, cyc, nb);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    logic       s;
    logic [9:0] r, e;
    int cyc, nb;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      run_op(8, a, b, s, r, cyc, nb);
      e = ref_op(8, a, b, s);
      total++;
      if (r !== e || cyc !== 8) begin
        bad++; $display("FAIL random a=%h b=%h sub=%b got=%h/%0d exp=%h/8", a, b, s, r, cyc, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] av [20];
    logic [9:0] e0, e1;
    int d0 = -1, d1 = -1, nd = 0, unstable = 0;
    b_in = 8'h3C; sub_in = 1'b0; st = 3'b001;
    for (int e = 0; e < 20; e++) begin
      av[e] = 8'($urandom);
      a_in = av[e];
      @(posedge clk); #1;
      if (done8) begin
        nd++;
        if (d0 < 0) d0 = e; else d1 = e;
      end
      if (e > 8 && e < 18 && d0 == 8 && {ovf8, cout8, sum8} !== ref_op(8, av[0], 8'h3C, 1'b0)) unstable++;
      if (e == 8) e0 = {ovf8, cout8, sum8};
      if (e == 18) e1 = {ovf8, cout8, sum8};
    end
    st = '0;
    total++;
    if (nd !== 2 || d0 !== 8 || d1 !== 18) begin
      bad++; $display("FAIL b2b done_edges got=%0d,%0d,%0d exp=8,18,2", d0, d1, nd);
    end
    total++;
    if (e0 !== ref_op(8, av[0], 8'h3C, 1'b0)) begin
      bad++; $display("FAIL b2b first got=%h exp=%h", e0, ref_op(8, av[0], 8'h3C, 1'b0));
    end
    total++;
    if (e1 !== ref_op(8, av[10], 8'h3C, 1'b0)) begin
      bad++; $display("FAIL b2b second got=%h exp=%h", e1, ref_op(8, av[10], 8'h3C, 1'b0));
    end
    total++;
    if (unstable !== 0) begin
      bad++; $display("FAIL b2b hold got=%0d changes exp=0", unstable);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop;
    logic [9:0] r;
    int cyc, nb, nd = 0;
    a_in = 8'h55; b_in = 8'h55; sub_in = 1'b0; st = 3'b001;
    @(posedge clk); #1;
    st = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h0) begin
      bad++; $display("FAIL midop_reset got=%h exp=0", {busy8, done8, sum8, cout8, ovf8});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      nd += int'(done8);
    end
    total++;
    if (nd !== 0) begin
      bad++; $display("FAIL midop_nodone got=%0d exp=0", nd);
    end
    run_op(8, 8'h55, 8'h55, 1'b0, r, cyc, nb);
    total++;
    if (r !== {2'b10, 8'hAA} || cyc !== 8) begin
      bad++; $display("FAIL midop_rerun got=%h/%0d exp=2aa/8", r, cyc);
    end
  endtask

  task automatic test_exhaustive(input int w);
    logic [9:0] r, e;
    int cyc, nb, nbad = 0;
    for (int a = 0; a < (1 << w); a++)
      for (int b = 0; b < (1 << w); b++)
        for (int s = 0; s < 2; s++) begin
          run_op(w, 8'(a), 8'(b), 1'(s), r, cyc, nb);
          e = ref_op(w, 8'(a), 8'(b), 1'(s));
          total++;
          if (r !== e || cyc !== w || nb !== w) begin
            bad++; nbad++;
            if (nbad < 10) $display("FAIL exh_w%0d a=%0d b=%0d sub=%0d got=%h/%0d/%0d exp=%h/%0d", w, a, b, s, r, cyc, nb, e, w);
          end
        end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_midop;
    test_exhaustive(1);
    test_exhaustive(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
